led_pattern_sequencer: RTL and testbench
========================================

# led_pattern_sequencer

Parametrised LED pattern engine: the next generation of the board's single-LED chaser. It drives a `WIDTH`-bit LED bank from the slow divided clock `div_clk`. It supports four selectable patterns, run/pause, a programmable step prescaler and both directions. It sits between the clock divider and the board LED pins, and reports a `wrap_pulse` for external chaining or counting.

## Interface
Parameters:
- `WIDTH`, default 8: number of LEDs. Must be even and ≥ 4.
- `PRESCALE_W`, default 4: width of the `speed` input and of the internal step counter.

Ports:
- `div_clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `enable`, input, 1: 1 = run, 0 = pause (all state held).
- `mode`, input, 2: 0 ROTATE, 1 BOUNCE, 2 FILL, 3 CONVERGE.
- `dir`, input, 1: 0 = toward MSB, 1 = toward LSB. Used by ROTATE and FILL; ignored by BOUNCE and CONVERGE.
- `speed`, input, `PRESCALE_W`: one step every `speed`+1 enabled cycles.
- `led`, output, `WIDTH`: registered LED pattern.
- `wrap_pulse`, output, 1: registered single-cycle flag on a wrap or reversal step.

## Operation
- Internal state:
  - `pos`: position, `$clog2(WIDTH)` bits.
  - `bdir`: bounce direction, 0 = up.
  - `cnt`: prescaler count, `PRESCALE_W` bits.
  - `mode_q`: registered copy of `mode`.
- Step generation:
  - `cnt` increments only while `enable`=1.
  - When `cnt` ≥ `speed`, that cycle is a step and `cnt` is set to 0.
  - Lowering `speed` below `cnt` therefore causes an immediate step, never a 2^PRESCALE_W-cycle stall.
- Each step computes `pos_n` and sets `led` to `decode(mode_q, dir, pos_n)` in the same edge.
- ROTATE:
  - `pos_n` = `pos`+1 when `dir`=0, `pos`−1 when `dir`=1, modulo `WIDTH`.
  - `led` = one-hot(`pos_n`).
  - `wrap_pulse` is asserted on the WIDTH−1→0 and 0→WIDTH−1 transitions.
- BOUNCE:
  - Single lit LED. `pos` moves up while `bdir`=0 and down while `bdir`=1.
  - At `pos`=WIDTH−1 going up: `bdir` flips, `pos_n`=WIDTH−2. At `pos`=0 going down: `bdir` flips, `pos_n`=1.
  - End LEDs are never shown twice in a row.
  - `wrap_pulse` is asserted on the step that lands on an end LED.
- FILL:
  - `pos` increments modulo `WIDTH`.
  - `dir`=0: `led` bits [`pos`:0] set. `dir`=1: `led` bits [WIDTH−1 : WIDTH−1−`pos`] set.
  - After all ones, the next step returns to a single LED (`pos`=0). `wrap_pulse` is asserted on that step.
- CONVERGE:
  - `led` = one-hot(`pos`) | one-hot(WIDTH−1−`pos`).
  - `pos` bounces between 0 and WIDTH/2−1 using `bdir` with the BOUNCE end rules.
  - `wrap_pulse` is asserted on the step that reaches either end.
- Mode change (`mode` ≠ `mode_q`, sampled every cycle regardless of `enable`):
  - On the next edge: `mode_q`←`mode`, `pos`←0, `bdir`←0, `cnt`←0, `led`←`decode(mode, dir, 0)`, `wrap_pulse`←0.
  - Any step pending in that cycle is discarded.
- `dir` change in ROTATE or FILL takes effect at the next step. `pos` is kept and `led` is unchanged until then.

## Timing
- Reset (async assert): `led`=1 (LSB only), `wrap_pulse`=0, `pos`=0, `bdir`=0, `cnt`=0, `mode_q`=0.
- Release is synchronous to `div_clk`. If `mode` ≠ 0 at release, the first edge performs a mode reload.
- Reset mid-pattern aborts immediately to the reset values.
- Step latency:
  - With `enable` held high and `speed`=S, `led` changes every S+1 edges.
  - After reset or reload, the first change occurs S+1 edges later.
  - `speed`=0 gives one step per edge.
- `wrap_pulse` is high for exactly one cycle, coincident with the `led` update that causes it. It is 0 on all non-step cycles and while paused.
- `enable`=0: `led`, `pos`, `bdir` and `cnt` are frozen. Resume continues from the frozen `cnt`.
- Decode initial values at `pos`=0 (WIDTH=8):
  - ROTATE: 0x01.
  - BOUNCE: 0x01.
  - FILL: 0x01 when `dir`=0, 0x80 when `dir`=1.
  - CONVERGE: 0x81.

## Test plan
- Reset with WIDTH=8, mode=0, dir=0, speed=0, enable=1 → `led` = 01, 02, 04 … 80, 01. `wrap_pulse` is high only on the 80→01 edge.
- ROTATE, dir=1 from reset → `led` = 01, 80, 40 … 02, 01. `wrap_pulse` is high on 01→80. Toggling `dir` mid-run reverses at the next step with no skipped LED.
- Switch mode to BOUNCE → `led`=01 on the next edge, then 02 … 80, 40 … 01, 02. `wrap_pulse` is high on arrival at 80 and at 01. No repeated end LED.
- FILL dir=0, speed=2 → `led` = 01, 03, 07 … FF, 01, changing every 3 edges. `wrap_pulse` is high on FF→01. Same sequence with dir=1 gives 80, C0 … FF.
- CONVERGE → `led` = 81, 42, 24, 18, 24, 42, 81. `wrap_pulse` is high on arrival at 18 and at 81. Pausing with `enable`=0 for 10 cycles holds `led`, and the sequence resumes with the same phase.
- Asynchronous `rst` pulse mid-step and between edges → `led`=01 and `wrap_pulse`=0 immediately. Lowering `speed` from 15 to 1 while `cnt`=9 → step on the next edge.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// LED pattern engine: rotate / bounce / fill / converge patterns on a WIDTH-bit bank,
// stepped by a programmable prescaler on the divided clock, with a wrap/reversal flag.
module led_pattern_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  div_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic                  dir,
    input  logic [PRESCALE_W-1:0] speed,
    output logic [WIDTH-1:0]      led,
    output logic                  wrap_pulse
);

    localparam int unsigned POS_W = $clog2(WIDTH);
    localparam logic [POS_W-1:0] LAST      = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] HALF_LAST = POS_W'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {
        ROTATE   = 2'd0,
        BOUNCE   = 2'd1,
        FILL     = 2'd2,
        CONVERGE = 2'd3
    } mode_t;

    mode_t                 mode_q;
    logic [POS_W-1:0]      pos;
    logic                  bdir;
    logic [PRESCALE_W-1:0] cnt;

    logic [POS_W-1:0]      pos_n;
    logic                  bdir_n;
    logic                  wrap_n;
    logic [POS_W-1:0]      top;
    logic                  step;
    logic                  reload;

    function automatic logic [WIDTH-1:0] mirror(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Pattern shown for a given mode, direction and position.
    function automatic logic [WIDTH-1:0] decode(input mode_t m, input logic d,
                                                input logic [POS_W-1:0] p);
        logic [WIDTH-1:0] one;
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] r;
        one  = WIDTH'(1) << p;
        fill = (one << 1) - WIDTH'(1);
        case (m)
            FILL:     r = d ? mirror(fill) : fill;
            CONVERGE: r = one | mirror(one);
            default:  r = one;
        endcase
        return r;
    endfunction

    assign reload = (mode_t'(mode) != mode_q);
    assign step   = enable && (cnt >= speed);

    // Next position, bounce direction and wrap flag for a step in the current mode.
    always_comb begin
        pos_n  = pos;
        bdir_n = bdir;
        wrap_n = 1'b0;
        top    = (mode_q == BOUNCE) ? LAST : HALF_LAST;
        case (mode_q)
            ROTATE: begin
                if (dir) begin
                    pos_n  = (pos == '0) ? LAST : pos - POS_W'(1);
                    wrap_n = (pos == '0);
                end else begin
                    pos_n  = (pos >= LAST) ? '0 : pos + POS_W'(1);
                    wrap_n = (pos >= LAST);
                end
            end
            FILL: begin
                pos_n  = (pos >= LAST) ? '0 : pos + POS_W'(1);
                wrap_n = (pos >= LAST);
            end
            default: begin
                if (!bdir) begin
                    if (pos >= top) begin
                        bdir_n = 1'b1;
                        pos_n  = top - POS_W'(1);
                    end else begin
                        pos_n  = pos + POS_W'(1);
                    end
                end else begin
                    if (pos == '0) begin
                        bdir_n = 1'b0;
                        pos_n  = POS_W'(1);
                    end else begin
                        pos_n  = pos - POS_W'(1);
                    end
                end
                wrap_n = (pos_n == top) || (pos_n == '0);
            end
        endcase
    end

    // A mode change outranks any pending step and restarts the pattern from position 0.
    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            mode_q     <= ROTATE;
            pos        <= '0;
            bdir       <= 1'b0;
            cnt        <= '0;
            led        <= WIDTH'(1);
            wrap_pulse <= 1'b0;
        end else if (reload) begin
            mode_q     <= mode_t'(mode);
            pos        <= '0;
            bdir       <= 1'b0;
            cnt        <= '0;
            led        <= decode(mode_t'(mode), dir, '0);
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (step) begin
                cnt        <= '0;
                pos        <= pos_n;
                bdir       <= bdir_n;
                led        <= decode(mode_q, dir, pos_n);
                wrap_pulse <= wrap_n;
            end else if (enable) begin
                cnt <= cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed pattern walks plus randomized stimulus
// compared every cycle against a step-count based reference model.
module tb_led_pattern_sequencer;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          div_clk;
    logic          rst;
    logic          enable;
    logic [1:0]    mode;
    logic          dir;
    logic [PW-1:0] speed;
    logic [W-1:0]  led;
    logic          wrap_pulse;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: mode, steps since reload, rotate position, prescaler count.
    int           m_mode;
    int           m_k;
    int           m_rpos;
    int           m_cnt;
    logic [W-1:0] m_led;
    logic         m_wrap;

    led_pattern_sequencer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .div_clk   (div_clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .dir       (dir),
        .speed     (speed),
        .led       (led),
        .wrap_pulse(wrap_pulse)
    );

    initial div_clk = 1'b0;
    always #5 div_clk = ~div_clk;

    function automatic logic [W-1:0] exp_pattern(int md, logic d, int p);
        logic [63:0] one_p;
        logic [63:0] one_q;
        logic [63:0] run;
        one_p = 64'd1 << p;
        one_q = 64'd1 << (W - 1 - p);
        run   = (64'd1 << (p + 1)) - 64'd1;
        case (md)
            2:       return d ? W'(run << (W - 1 - p)) : W'(run);
            3:       return W'(one_p | one_q);
            default: return W'(one_p);
        endcase
    endfunction

    // Triangle wave 0..top..0 indexed by step number.
    function automatic int tri_pos(int k, int top);
        int ph;
        ph = k % (2 * top);
        return (ph <= top) ? ph : 2 * top - ph;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_k    = 0;
        m_rpos = 0;
        m_cnt  = 0;
        m_led  = W'(1);
        m_wrap = 1'b0;
    endtask

    task automatic model_step();
        int p;
        int top;
        m_k++;
        case (m_mode)
            0: begin
                if (dir) begin
                    m_wrap = (m_rpos == 0);
                    m_rpos = (m_rpos + W - 1) % W;
                end else begin
                    m_wrap = (m_rpos == W - 1);
                    m_rpos = (m_rpos + 1) % W;
                end
                p = m_rpos;
            end
            2: begin
                p      = m_k % W;
                m_wrap = (p == 0);
            end
            default: begin
                top    = (m_mode == 1) ? W - 1 : W / 2 - 1;
                p      = tri_pos(m_k, top);
                m_wrap = (p == 0) || (p == top);
            end
        endcase
        m_led = exp_pattern(m_mode, dir, p);
    endtask

    task automatic model_edge();
        if (int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_k    = 0;
            m_rpos = 0;
            m_cnt  = 0;
            m_wrap = 1'b0;
            m_led  = exp_pattern(m_mode, dir, 0);
        end else begin
            m_wrap = 1'b0;
            if (enable) begin
                if (m_cnt >= int'(speed)) begin
                    m_cnt = 0;
                    model_step();
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge div_clk);
        model_edge();
        #1;
        check("led", led, m_led);
        check("wrap", W'(wrap_pulse), W'(m_wrap));
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_led", led, W'(1));
        check("async_rst_wrap", W'(wrap_pulse), W'(0));
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    logic [W-1:0] conv_exp [7];

    initial begin
        conv_exp = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h24, 8'h42, 8'h81};
        rst    = 1'b1;
        enable = 1'b1;
        mode   = 2'd0;
        dir    = 1'b0;
        speed  = '0;
        model_reset();
        #1;
        check("reset_led", led, W'(1));
        check("reset_wrap", W'(wrap_pulse), W'(0));
        @(posedge div_clk);
        #1;
        check("reset_held_led", led, W'(1));
        rst = 1'b0;

        // Rotate toward MSB at full speed.
        for (int i = 0; i < 9; i++) begin
            tick();
            check("rot_up_lit", led, W'(1) << ((i + 1) % W));
            check("rot_up_wrap_lit", W'(wrap_pulse), W'(i == W - 1));
        end

        // Rotate toward LSB from reset, then reverse mid-run.
        do_reset();
        dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rot_dn_lit", led, W'(1) << (W - 1 - i));
            check("rot_dn_wrap_lit", W'(wrap_pulse), W'(i == 0));
        end
        tick();
        tick();
        dir = 1'b0;
        repeat (4) tick();

        // Bounce through both ends.
        mode = 2'd1;
        tick();
        check("bounce_reload_lit", led, W'(1));
        repeat (16) tick();

        // Fill with prescaler, both directions.
        mode  = 2'd2;
        speed = PW'(2);
        repeat (28) tick();
        dir = 1'b1;
        repeat (28) tick();

        // Converge at full speed, then pause and resume.
        speed = '0;
        mode  = 2'd3;
        tick();
        check("conv_lit0", led, conv_exp[0]);
        for (int i = 1; i < 7; i++) begin
            tick();
            check("conv_lit", led, conv_exp[i]);
            check("conv_wrap_lit", W'(wrap_pulse), W'(i == 3 || i == 6));
        end
        tick();
        enable = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        repeat (6) tick();

        // Lowering speed below the current count forces a step on the next edge.
        mode  = 2'd1;
        speed = PW'(15);
        tick();
        repeat (9) tick();
        speed = PW'(1);
        tick();
        check("speed_drop_lit", led, W'(2));

        do_reset();

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 19) == 0)
                speed = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 15))
                                                    : PW'($urandom_range(0, 2));
            tick();
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
